// File: rtl/shared_mac_scheduler.sv
// Shares one signed 8x8 multiplier and one 16-bit adder between two requesters.
// A = x1*K1 + x2*K2 and B = v*t + c, with round-robin arbitration.
//
// state | meaning
// IDLE  | arbitrate; a grant captures the operands and selects the equation
// MUL1  | acc <= first product (x1*K1 or v*t)
// MUL2  | acc <= acc + second product (x2*K2 or c*1)
// DONE  | copy acc to the selected result register and pulse its valid
module shared_mac_scheduler #(
  parameter logic signed [7:0] K1 = 8'sd3,
  parameter logic signed [7:0] K2 = 8'sd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [7:0]  a_x1,
  input  logic [7:0]  a_x2,
  output logic        a_gnt,
  output logic        a_valid,
  output logic [15:0] a_result,
  input  logic        b_req,
  input  logic [7:0]  b_v,
  input  logic [7:0]  b_t,
  input  logic [7:0]  b_c,
  output logic        b_gnt,
  output logic        b_valid,
  output logic [15:0] b_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  state_t             state, state_nxt;
  logic               sel_b, last_b;
  logic               grant_a, grant_b;
  logic signed [7:0]  op0, op1, op2;
  logic signed [7:0]  mul_a, mul_b;
  logic signed [15:0] acc, product, add_a, sum;

  // Grants are combinational so they coincide with the capturing edge.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE && rst_n) begin
      if (a_req && (!b_req || last_b)) grant_a = 1'b1;
      else if (b_req)                  grant_b = 1'b1;
    end
  end

  assign a_gnt = grant_a;
  assign b_gnt = grant_b;
  assign busy  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_a || grant_b) state_nxt = MUL1;
      MUL1:    state_nxt = MUL2;
      MUL2:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // c is routed through the multiplier as c*1, so the adder only ever sees acc.
  always_comb begin
    mul_a = op0;
    mul_b = sel_b ? op1 : K1;
    add_a = '0;
    if (state == MUL2) begin
      mul_a = sel_b ? op2 : op1;
      mul_b = sel_b ? 8'sd1 : K2;
      add_a = acc;
    end
  end

  assign product = $signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b});
  assign sum     = add_a + product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_b    <= 1'b0;
      last_b   <= 1'b1;
      op0      <= '0;
      op1      <= '0;
      op2      <= '0;
      acc      <= '0;
      a_result <= '0;
      b_result <= '0;
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
    end else begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      if (grant_a) begin
        sel_b  <= 1'b0;
        last_b <= 1'b0;
        op0    <= a_x1;
        op1    <= a_x2;
      end
      if (grant_b) begin
        sel_b  <= 1'b1;
        last_b <= 1'b1;
        op0    <= b_v;
        op1    <= b_t;
        op2    <= b_c;
      end
      if (state == MUL1 || state == MUL2) acc <= sum;
      if (state == DONE) begin
        if (sel_b) begin
          b_result <= acc;
          b_valid  <= 1'b1;
        end else begin
          a_result <= acc;
          a_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shared_mac_scheduler.sv
// Directed bench for shared_mac_scheduler: reset, single ops, arbitration,
// signed extremes and reset in the middle of an operation.
module tb_shared_mac_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req;
  logic [7:0]  a_x1, a_x2, b_v, b_t, b_c;
  logic        a_gnt, a_valid, b_gnt, b_valid, busy;
  logic [15:0] a_result, b_result;

  int n_chk  = 0;
  int n_fail = 0;

  shared_mac_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_x1     (a_x1),
    .a_x2     (a_x2),
    .a_gnt    (a_gnt),
    .a_valid  (a_valid),
    .a_result (a_result),
    .b_req    (b_req),
    .b_v      (b_v),
    .b_t      (b_t),
    .b_c      (b_c),
    .b_gnt    (b_gnt),
    .b_valid  (b_valid),
    .b_result (b_result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request alone and follows it to completion (grant edge N, valid after N+3).
  task automatic run_op(input string tag, input bit is_b, input logic [7:0] p,
                        input logic [7:0] q, input logic [7:0] r, input logic [15:0] exp);
    if (is_b) begin
      b_req = 1'b1; b_v = p; b_t = q; b_c = r;
    end else begin
      a_req = 1'b1; a_x1 = p; a_x2 = q;
    end
    #1;
    chk({tag, "_gnt"}, is_b ? b_gnt : a_gnt, 16'd1);
    chk({tag, "_other_gnt"}, is_b ? a_gnt : b_gnt, 16'd0);
    tick();
    a_req = 1'b0;
    b_req = 1'b0;
    chk({tag, "_busy"}, busy, 16'd1);
    tick();
    chk({tag, "_early_valid1"}, is_b ? b_valid : a_valid, 16'd0);
    tick();
    chk({tag, "_early_valid2"}, is_b ? b_valid : a_valid, 16'd0);
    tick();
    chk({tag, "_valid"}, is_b ? b_valid : a_valid, 16'd1);
    chk({tag, "_other_valid"}, is_b ? a_valid : b_valid, 16'd0);
    chk({tag, "_result"}, is_b ? b_result : a_result, exp);
    chk({tag, "_idle"}, busy, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    a_x1 = '0; a_x2 = '0; b_v = '0; b_t = '0; b_c = '0;
    tick();
    tick();
    chk("rst_a_result", a_result, 16'h0000);
    chk("rst_b_result", b_result, 16'h0000);
    chk("rst_valids", {14'd0, a_valid, b_valid}, 16'd0);
    chk("rst_gnts", {14'd0, a_gnt, b_gnt}, 16'd0);
    chk("rst_busy", busy, 16'd0);
    rst_n = 1'b1;
    tick();

    // Tie straight after reset: A must win.
    a_req = 1'b1; b_req = 1'b1;
    #1;
    chk("tie_a_gnt", a_gnt, 16'd1);
    chk("tie_b_gnt", b_gnt, 16'd0);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("tie_no_capture", busy, 16'd0);

    run_op("single_a", 1'b0, 8'd2, 8'd4, 8'd0, 16'h001A);
    chk("single_a_b_result", b_result, 16'h0000);
    tick();
    chk("single_a_valid_drop", a_valid, 16'd0);
    chk("single_a_hold", a_result, 16'h001A);

    run_op("single_b", 1'b1, 8'hFD, 8'd7, 8'd10, 16'hFFF5);
    chk("single_b_a_result", a_result, 16'h001A);

    // Both held high: grants alternate A,B,A,B every 4 cycles.
    a_req = 1'b1; a_x1 = 8'd1; a_x2 = 8'd1;
    b_req = 1'b1; b_v = 8'd2; b_t = 8'd3; b_c = 8'd4;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("arb_a_gnt", a_gnt, (k % 2 == 0) ? 16'd1 : 16'd0);
      chk("arb_b_gnt", b_gnt, (k % 2 == 1) ? 16'd1 : 16'd0);
      tick();
      for (int j = 0; j < 3; j++) begin
        chk("arb_busy_no_gnt", {14'd0, a_gnt, b_gnt}, 16'd0);
        chk("arb_valid_overlap", {15'd0, a_valid & b_valid}, 16'd0);
        tick();
      end
      chk("arb_valid_overlap_done", {15'd0, a_valid & b_valid}, 16'd0);
      if (k % 2 == 0) begin
        chk("arb_a_valid", a_valid, 16'd1);
        chk("arb_a_result", a_result, 16'd8);
      end else begin
        chk("arb_b_valid", b_valid, 16'd1);
        chk("arb_b_result", b_result, 16'd10);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("arb_end_valids", {14'd0, a_valid, b_valid}, 16'd0);

    run_op("ext_a", 1'b0, 8'h80, 8'h80, 8'd0, 16'hFC00);
    run_op("ext_b", 1'b1, 8'h80, 8'h80, 8'd127, 16'h407F);
    chk("ext_b_a_hold", a_result, 16'hFC00);

    // Reset while an A operation is in MUL2.
    a_req = 1'b1; a_x1 = 8'd2; a_x2 = 8'd4;
    #1;
    chk("midrst_a_gnt", a_gnt, 16'd1);
    tick();
    a_req = 1'b0;
    tick();
    b_req = 1'b1; b_v = 8'd1; b_t = 8'd1; b_c = 8'd1;
    rst_n = 1'b0;
    #1;
    chk("midrst_a_result", a_result, 16'h0000);
    chk("midrst_b_result", b_result, 16'h0000);
    chk("midrst_busy", busy, 16'd0);
    chk("midrst_gnts", {14'd0, a_gnt, b_gnt}, 16'd0);
    tick();
    chk("midrst_no_valid", {14'd0, a_valid, b_valid}, 16'd0);
    rst_n = 1'b1;
    run_op("midrst_b", 1'b1, 8'd1, 8'd1, 8'd1, 16'h0002);
    chk("midrst_a_still0", a_result, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
